ps2_kb_controller: RTL and testbench
====================================

Name: ps2_kb_controller

Overview:
- Synchronous PS/2 keyboard front end for the processor I/O space.
- Oversamples the raw KB_Clk/KB_Data lines in the system clock domain.
- Frames and checks each 11-bit PS/2 frame (start, 8 data LSB-first, odd parity, stop) and decodes make/break sequences.
- Queues key-release scan codes in a small FIFO that the CPU drains with a read strobe.

Parameters:
- FIFO_DEPTH, 8, number of queued scan codes; must be a power of 2, at least 2.
- PTR_W, 3, log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 5000, Clk cycles without a KB_Clk falling edge before a partial frame is abandoned.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- KB_Clk  input  1  raw PS/2 clock from the connector; asynchronous to Clk.
- KB_Data  input  1  raw PS/2 data from the connector; asynchronous to Clk.
- Rd_En  input  1  CPU pop strobe, sampled on the rising edge of Clk.
- KB_Char  output  8  head-of-FIFO scan code; 8'h00 when the FIFO is empty.
- Char_Valid  output  1  FIFO non-empty.
- Fifo_Full  output  1  FIFO holds FIFO_DEPTH entries.
- Frame_Err  output  1  one-cycle pulse on parity, stop-bit or timeout error.
- Overflow  output  1  sticky; a release code was dropped because the FIFO was full.

Behaviour:
- Reset (async, any time including mid-frame):
  - Outputs: KB_Char=8'h00, Char_Valid=0, Fifo_Full=0, Frame_Err=0, Overflow=0.
  - Internal state: FSM=IDLE, bit counter=0, timeout counter=0, Break_Pending=0, FIFO pointers=0, count=0.
  - Both synchronizer stages reset to 1 (idle bus), so no false edge is seen after reset.
- Input sampling:
  - KB_Clk and KB_Data each pass through a 2-FF synchronizer.
  - A falling edge is detected when the previous synced KB_Clk is 1 and the current synced KB_Clk is 0.
  - Synced KB_Data is sampled in the same cycle the edge is detected.
- Frame FSM; states advance only on a detected falling edge:
  - IDLE: data=0 goes to DATA with bit counter=0. Data=1 is a glitch; stay in IDLE.
  - DATA: shift data into bit[counter], LSB first. On the 8th bit (counter=7), go to PARITY.
  - PARITY: capture the parity bit. The parity check passes iff XOR(data[7:0], parity)=1. Go to STOP.
  - STOP: the frame is good iff stop=1 and parity passed; a good frame hands its byte to the decoder. Any failure pulses Frame_Err and discards the byte. Always return to IDLE.
- Timeout:
  - The counter runs in any state except IDLE and clears on every detected edge.
  - On reaching TIMEOUT_CYCLES-1: pulse Frame_Err, go to IDLE, discard the partial byte.
  - Break_Pending is unchanged.
- Decoder, one good byte per frame:
  - 8'hF0: set Break_Pending; no push.
  - 8'hE0: ignored; no push, Break_Pending unchanged.
  - Any other byte with Break_Pending=1: push the byte and clear Break_Pending.
  - Any other byte with Break_Pending=0: make code; no push.
- Latency:
  - Char_Valid (and KB_Char for a previously empty FIFO) update exactly 2 Clk cycles after the cycle in which the stop-bit edge is detected.
  - Frame_Err asserts 1 cycle after the failing edge or the timeout.
- FIFO:
  - Show-ahead: KB_Char always presents the head entry. Circular pointers wrap at FIFO_DEPTH; an occupancy count of width PTR_W+1 gives Full and Empty.
  - Rd_En=1 with Char_Valid=1: pop, and the next entry appears the following cycle.
  - Rd_En=1 while empty: ignored, no pointer change.
  - Push while full with no pop: the byte is dropped and Overflow sets.
  - Push and pop in the same cycle while full: both succeed; count unchanged, no drop.
  - Push and pop in the same cycle while empty: the pop is ignored and the push is stored.
  - Overflow stays set until Reset or the first accepted pop, whichever comes first.

Test Plan:
- Release detection: frames 1C, F0, 1C with KB_Clk half-period 20 Clk -> one entry. KB_Char=8'h1C and Char_Valid=1 two cycles after the third stop edge; one Rd_En -> Char_Valid=0, KB_Char=8'h00.
- Extended key: frames E0, 75, E0, F0, 75 -> exactly one entry, 8'h75. No Frame_Err.
- Parity error: frame F0 with the parity bit forced to 0 -> one-cycle Frame_Err; Break_Pending stays 0. A following frame 1C is not pushed.
- Timeout: with TIMEOUT_CYCLES=200, send the start bit plus 3 data bits, then stall -> Frame_Err 200 cycles after the last edge. A following full F0, 2D sequence pushes 8'h2D.
- Overflow and simultaneous access:
  - 9 release sequences (F0,xx) for xx=01..09 with no reads -> Fifo_Full=1, Overflow=1, entries 01..08.
  - Then Rd_En held during the push of F0,0A while full -> no drop; the FIFO drains 02..08, 0A.
  - Overflow clears on the first pop.
- Reset mid-frame: assert Reset after 5 data bits of a frame -> all outputs 0, FIFO empty. The next complete F0, 1C sequence yields a single 8'h1C.

Source files
------------

// File: rtl/ps2_kb_controller.sv
// PS/2 keyboard front end: synchronises the raw bus, frames 11-bit words,
// decodes break (F0) sequences and queues released scan codes for the CPU.
module ps2_kb_controller #(
    parameter int FIFO_DEPTH     = 8,
    parameter int PTR_W          = 3,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       KB_Clk,
    input  logic       KB_Data,
    input  logic       Rd_En,
    output logic [7:0] KB_Char,
    output logic       Char_Valid,
    output logic       Fifo_Full,
    output logic       Frame_Err,
    output logic       Overflow
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]      r_clkSync;
    logic [1:0]      r_dataSync;
    logic            r_clkPrev;
    logic            w_fall;
    logic            w_data;

    state_t          r_state;
    state_t          w_stateNext;
    logic [2:0]      r_bitCnt;
    logic [2:0]      w_bitCntNext;
    logic [7:0]      r_shift;
    logic [7:0]      w_shiftNext;
    logic            r_parity;
    logic            w_parityNext;
    logic [TO_W-1:0] r_toCnt;
    logic [TO_W-1:0] w_toCntNext;
    logic            w_errNext;
    logic            w_goodNext;

    logic            r_frameErr;
    logic            r_byteValid;
    logic [7:0]      r_rxByte;
    logic            r_breakPending;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W:0]  r_count;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_write;

    // Synchronisers idle high so leaving reset never looks like a falling edge
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkPrev  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], KB_Clk};
            r_dataSync <= {r_dataSync[0], KB_Data};
            r_clkPrev  <= r_clkSync[1];
        end
    end

    assign w_fall = r_clkPrev & ~r_clkSync[1];
    assign w_data = r_dataSync[1];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= 3'd0;
            r_shift     <= 8'h00;
            r_parity    <= 1'b0;
            r_toCnt     <= '0;
            r_frameErr  <= 1'b0;
            r_byteValid <= 1'b0;
            r_rxByte    <= 8'h00;
        end else begin
            r_state     <= w_stateNext;
            r_bitCnt    <= w_bitCntNext;
            r_shift     <= w_shiftNext;
            r_parity    <= w_parityNext;
            r_toCnt     <= w_toCntNext;
            r_frameErr  <= w_errNext;
            r_byteValid <= w_goodNext;
            if (w_goodNext) begin
                r_rxByte <= r_shift;
            end
        end
    end

    // A bus edge always wins over an expiring timeout in the same cycle
    always_comb begin
        w_stateNext  = r_state;
        w_bitCntNext = r_bitCnt;
        w_shiftNext  = r_shift;
        w_parityNext = r_parity;
        w_toCntNext  = r_toCnt;
        w_errNext    = 1'b0;
        w_goodNext   = 1'b0;
        if (r_state != S_IDLE) begin
            w_toCntNext = r_toCnt + 1'b1;
        end
        if (w_fall) begin
            w_toCntNext = '0;
            case (r_state)
                S_IDLE: begin
                    if (!w_data) begin
                        w_stateNext  = S_DATA;
                        w_bitCntNext = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shiftNext[r_bitCnt] = w_data;
                    w_bitCntNext = r_bitCnt + 3'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_parityNext = w_data;
                    w_stateNext  = S_STOP;
                end
                default: begin
                    if (w_data && ((^r_shift) ^ r_parity)) begin
                        w_goodNext = 1'b1;
                    end else begin
                        w_errNext = 1'b1;
                    end
                    w_stateNext = S_IDLE;
                end
            endcase
        end else if (r_state != S_IDLE && r_toCnt == TO_LAST) begin
            w_errNext   = 1'b1;
            w_stateNext = S_IDLE;
            w_toCntNext = '0;
        end
    end

    // Only the byte following an F0 prefix is queued; E0 is transparent
    assign w_push  = r_byteValid && r_breakPending &&
                     (r_rxByte != 8'hF0) && (r_rxByte != 8'hE0);
    assign w_pop   = Rd_En && (r_count != '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_breakPending <= 1'b0;
        end else if (r_byteValid) begin
            if (r_rxByte == 8'hF0) begin
                r_breakPending <= 1'b1;
            end else if (r_rxByte != 8'hE0) begin
                r_breakPending <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= r_rxByte;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_overflow <= 1'b0;
            end else if (w_push && !w_write) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign KB_Char    = (r_count != '0) ? r_mem[r_rdPtr] : 8'h00;
    assign Char_Valid = (r_count != '0);
    assign Fifo_Full  = w_full;
    assign Frame_Err  = r_frameErr;
    assign Overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_kb_controller.sv
// Scoreboard bench for ps2_kb_controller: a PS/2 frame driver, a decode model
// feeding an expected-code queue, and a monitor that checks every accepted pop.
module tb_ps2_kb_controller;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;

    logic       Clk;
    logic       Reset;
    logic       KB_Clk;
    logic       KB_Data;
    logic       Rd_En;
    logic [7:0] KB_Char;
    logic       Char_Valid;
    logic       Fifo_Full;
    logic       Frame_Err;
    logic       Overflow;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    int lastFallCyc = 0;
    int errCount = 0;
    int expErr   = 0;
    bit errPrev  = 0;

    bit autoRead  = 0;
    bit forceRead = 0;

    logic [7:0] expQ[$];
    bit         modelBreak = 0;
    bit         modelOvf   = 0;
    logic [7:0] pendByte;
    bit         pendGood;

    ps2_kb_controller #(
        .FIFO_DEPTH(DEPTH),
        .PTR_W(3),
        .TIMEOUT_CYCLES(200)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .KB_Clk(KB_Clk),
        .KB_Data(KB_Data),
        .Rd_En(Rd_En),
        .KB_Char(KB_Char),
        .Char_Valid(Char_Valid),
        .Fifo_Full(Fifo_Full),
        .Frame_Err(Frame_Err),
        .Overflow(Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input bit ok, input string name, input int act, input int req);
        nChecks++;
        if (ok) nPass++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Reference decoder: F0 arms a release, E0 is ignored, armed byte is queued
    task automatic modelByte(input logic [7:0] b, input bit popSameCycle);
        if (b == 8'hF0) begin
            modelBreak = 1;
        end else if (b != 8'hE0) begin
            if (modelBreak) begin
                if (expQ.size() >= DEPTH && !popSameCycle) modelOvf = 1;
                else expQ.push_back(b);
            end
            modelBreak = 0;
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        modelBreak = 0;
        modelOvf   = 0;
    endtask

    // mode 1: check push latency, mode 2: pop in the push cycle, mode 3: check error latency
    task automatic sendBit(input logic b, input bit isStop, input int mode, input logic [7:0] eb);
        @(negedge Clk);
        KB_Data = b;
        repeat (HALF / 2) @(negedge Clk);
        KB_Clk = 1'b0;
        lastFallCyc = cyc;
        if (isStop) begin
            if (pendGood) modelByte(pendByte, mode == 2);
            else expErr++;
        end
        case (mode)
            1: begin
                repeat (3) @(negedge Clk);
                check(Char_Valid == 1'b0, "latencyEarly", Char_Valid, 0);
                @(negedge Clk);
                check(Char_Valid == 1'b1, "latencyValid", Char_Valid, 1);
                check(KB_Char == eb, "latencyChar", KB_Char, eb);
                repeat (HALF - 4) @(negedge Clk);
            end
            2: begin
                repeat (3) @(posedge Clk);
                forceRead = 1;
                @(posedge Clk);
                forceRead = 0;
                repeat (HALF - 4) @(negedge Clk);
            end
            3: begin
                repeat (2) @(negedge Clk);
                check(Frame_Err == 1'b0, "errEarly", Frame_Err, 0);
                @(negedge Clk);
                check(Frame_Err == 1'b1, "errLatency", Frame_Err, 1);
                repeat (HALF - 3) @(negedge Clk);
            end
            default: repeat (HALF) @(negedge Clk);
        endcase
        KB_Clk = 1'b1;
        repeat (HALF / 2) @(negedge Clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit badPar, input bit badStop, input int mode);
        logic p;
        p = ~^b;
        if (badPar) p = ~p;
        pendByte = b;
        pendGood = !badPar && !badStop;
        sendBit(1'b0, 0, 0, b);
        for (int i = 0; i < 8; i++) sendBit(b[i], 0, 0, b);
        sendBit(p, 0, 0, b);
        sendBit(!badStop, 1, mode, b);
        KB_Data = 1'b1;
    endtask

    task automatic readOnce();
        @(posedge Clk);
        forceRead = 1;
        @(posedge Clk);
        forceRead = 0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic checkOutput(input string name);
        repeat (3) @(negedge Clk);
        check(Char_Valid == (expQ.size() != 0), {name, "_valid"}, Char_Valid, expQ.size() != 0);
        if (expQ.size() != 0) check(KB_Char == expQ[0], {name, "_head"}, KB_Char, expQ[0]);
        else check(KB_Char == 8'h00, {name, "_emptyChar"}, KB_Char, 0);
        check(Overflow == modelOvf, {name, "_ovf"}, Overflow, modelOvf);
        check(errCount == expErr, {name, "_errCount"}, errCount, expErr);
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        autoRead = 1;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge Clk);
            if (expQ.size() == 0 && !Char_Valid) done = 1;
        end
        check(done, {name, "_drained"}, expQ.size(), 0);
        autoRead = 0;
        checkOutput(name);
    endtask

    task automatic checkResetOutputs(input string name);
        check(KB_Char == 8'h00, {name, "_char"}, KB_Char, 0);
        check(Char_Valid == 1'b0, {name, "_valid"}, Char_Valid, 0);
        check(Fifo_Full == 1'b0, {name, "_full"}, Fifo_Full, 0);
        check(Frame_Err == 1'b0, {name, "_err"}, Frame_Err, 0);
        check(Overflow == 1'b0, {name, "_ovf"}, Overflow, 0);
    endtask

    // CPU read strobe, changed just after each rising edge
    initial begin
        Rd_En = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            Rd_En = forceRead || (autoRead && (Char_Valid || ($urandom_range(0, 3) == 0)));
        end
    end

    // Monitor: every accepted pop is compared with the scoreboard head
    initial forever begin
        logic [7:0] e;
        @(negedge Clk);
        if (!Reset && Rd_En && Char_Valid) begin
            if (expQ.size() == 0) begin
                check(1'b0, "unexpectedPop", KB_Char, 0);
            end else begin
                e = expQ.pop_front();
                check(KB_Char == e, "popData", KB_Char, e);
                modelOvf = 0;
            end
        end
        if (errPrev) check(Frame_Err == 1'b0, "errPulseWidth", Frame_Err, 0);
        if (Frame_Err && !errPrev) errCount++;
        errPrev = Frame_Err;
    end

    initial begin
        #(10 * 95000);
        $display("[TB] FAIL watchdog: actual=%0d required=%0d", cyc, 95000);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit found;
        int delta;
        Reset   = 1'b1;
        KB_Clk  = 1'b1;
        KB_Data = 1'b1;
        repeat (3) @(negedge Clk);
        checkResetOutputs("reset");
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        $display("[TB] release detection");
        applyStimulus(8'h1C, 0, 0, 0);
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h1C, 0, 0, 1);
        readOnce();
        checkOutput("release");

        $display("[TB] extended key");
        applyStimulus(8'hE0, 0, 0, 0);
        applyStimulus(8'h75, 0, 0, 0);
        applyStimulus(8'hE0, 0, 0, 0);
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h75, 0, 0, 0);
        checkOutput("extended");
        check(expQ.size() == 1 && KB_Char == 8'h75, "extendedOne", KB_Char, 8'h75);
        readOnce();
        checkOutput("extendedRead");

        $display("[TB] parity error");
        applyStimulus(8'hF0, 1, 0, 3);
        applyStimulus(8'h1C, 0, 0, 0);
        checkOutput("parity");

        $display("[TB] timeout");
        sendBit(1'b0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) sendBit(i[0], 0, 0, 8'h00);
        expErr++;
        found = 0;
        delta = 0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge Clk);
            if (Frame_Err) begin
                found = 1;
                delta = cyc - lastFallCyc;
            end
        end
        check(found, "timeoutSeen", found, 1);
        check(delta >= 200 && delta <= 206, "timeoutDelay", delta, 203);
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h2D, 0, 0, 0);
        checkOutput("timeout");
        readOnce();
        checkOutput("timeoutRead");

        $display("[TB] overflow");
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(8'hF0, 0, 0, 0);
            applyStimulus(8'(i), 0, 0, 0);
        end
        checkOutput("overflow");
        check(Fifo_Full == (expQ.size() == DEPTH), "overflowFull", Fifo_Full, 1);
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h0A, 0, 0, 2);
        checkOutput("pushPopFull");
        check(Fifo_Full == (expQ.size() == DEPTH), "pushPopFullFlag", Fifo_Full, 1);
        drain("overflowDrain");

        $display("[TB] reset mid-frame");
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h33, 0, 0, 0);
        checkOutput("preReset");
        sendBit(1'b0, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) sendBit(i[0], 0, 0, 8'h00);
        @(negedge Clk);
        Reset = 1'b1;
        modelReset();
        repeat (2) @(negedge Clk);
        checkResetOutputs("midReset");
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        checkResetOutputs("postReset");
        applyStimulus(8'hF0, 0, 0, 0);
        applyStimulus(8'h1C, 0, 0, 0);
        checkOutput("afterReset");
        readOnce();
        checkOutput("afterResetRead");

        $display("[TB] random traffic");
        autoRead = 1;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int kind;
            int err;
            kind = $urandom_range(0, 9);
            err  = $urandom_range(0, 9);
            if (kind < 3) b = 8'hF0;
            else if (kind == 3) b = 8'hE0;
            else b = 8'($urandom);
            applyStimulus(b, err == 0, err == 1, 0);
        end
        drain("random");

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
